dma_fifo_buffer: RTL and testbench

Word FIFO that sits directly upstream of the CPU output datapath stage and drives its OD[31:0] head-of-queue data. The DMA control logic fills it from either:
- the 32-bit internal data bus, as 16-bit halves, or
- the SCSI byte path, as single bytes packed by a lane pointer.

It drains one word per DECFIFO. Occupancy flags go back to the DMA state machine.

---
 rtl/dma_fifo_buffer.sv | 133 +++++++++++++
 tb/tb_dma_fifo_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dma_fifo_buffer                                                  |
// | Brief   : DMA word FIFO filled by 16-bit halves or packed bytes, drained    |
// |           one word per DECFIFO; head word drives OD combinationally.       |
// | Option  : DMA_FIFO_ERR_EN adds sticky OVFERR / UNFERR outputs.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dma_fifo_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        CLK,
  input  logic        RST_,
  input  logic [31:0] ID,
  input  logic        LLWORD,
  input  logic        LHWORD,
  input  logic        WRBYTE,
  input  logic        INCFIFO,
  input  logic        DECFIFO,
  input  logic        FLUSH,
  output logic [31:0] OD,
  output logic [1:0]  BO,
  output logic        FIFOFULL,
`ifdef DMA_FIFO_ERR_EN
  output logic        OVFERR,
  output logic        UNFERR,
`endif
  output logic        FIFOEMPTY
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_bo;

  logic          w_full;
  logic          w_empty;
  logic          w_inc_ok;
  logic          w_dec_ok;
  logic          w_wr_en;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_inc_ok = INCFIFO & ~w_full;
  assign w_dec_ok = DECFIFO & ~w_empty;

  // When full the write entry aliases the head entry, so lane writes are
  // blocked to keep OD stable; FLUSH also leaves memory untouched.
  assign w_wr_en  = ~FLUSH & ~w_full;

  assign w_be[0] = w_wr_en & (LLWORD | (WRBYTE & (r_bo == 2'd0)));
  assign w_be[1] = w_wr_en & (LLWORD | (WRBYTE & (r_bo == 2'd1)));
  assign w_be[2] = w_wr_en & (LHWORD | (WRBYTE & (r_bo == 2'd2)));
  assign w_be[3] = w_wr_en & (LHWORD | (WRBYTE & (r_bo == 2'd3)));

  // Halfword strobes take the lane from their own ID bits; a byte write
  // always sources ID[7:0].
  assign w_wdata = {LHWORD ? ID[31:24] : ID[7:0],
                    LHWORD ? ID[23:16] : ID[7:0],
                    LLWORD ? ID[15:8]  : ID[7:0],
                    ID[7:0]};

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        r_mem[r_wr_ptr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bo     <= 2'd0;
    end else if (FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bo     <= 2'd0;
    end else begin
      if (w_inc_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_dec_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_inc_ok} - {{AW{1'b0}}, w_dec_ok};
      if (INCFIFO) begin
        r_bo <= 2'd0;
      end else if (WRBYTE) begin
        r_bo <= r_bo + 2'd1;
      end
    end
  end

`ifdef DMA_FIFO_ERR_EN
  logic r_ovferr;
  logic r_unferr;

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      r_ovferr <= 1'b0;
      r_unferr <= 1'b0;
    end else if (FLUSH) begin
      r_ovferr <= 1'b0;
      r_unferr <= 1'b0;
    end else begin
      if (INCFIFO & w_full) begin
        r_ovferr <= 1'b1;
      end
      if (DECFIFO & w_empty) begin
        r_unferr <= 1'b1;
      end
    end
  end

  assign OVFERR = r_ovferr;
  assign UNFERR = r_unferr;
`endif

  assign OD        = r_mem[r_rd_ptr];
  assign BO        = r_bo;
  assign FIFOFULL  = w_full;
  assign FIFOEMPTY = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_dma_fifo_buffer.sv
`default_nettype none
// Testbench for dma_fifo_buffer: directed scenarios plus randomized traffic
// compared against an array/counter reference model.
module tb_dma_fifo_buffer;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST_ = 1'b0;
  logic [31:0] ID = '0;
  logic        LLWORD = 1'b0, LHWORD = 1'b0, WRBYTE = 1'b0;
  logic        INCFIFO = 1'b0, DECFIFO = 1'b0, FLUSH = 1'b0;
  logic [31:0] OD;
  logic [1:0]  BO;
  logic        FIFOFULL, FIFOEMPTY;
`ifdef DMA_FIFO_ERR_EN
  logic        OVFERR, UNFERR;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_wr, m_rd, m_cnt, m_bo;
  bit          m_ovf, m_unf;

  dma_fifo_buffer #(.DEPTH(DEPTH), .AW(3)) dut (
    .CLK       (CLK),
    .RST_      (RST_),
    .ID        (ID),
    .LLWORD    (LLWORD),
    .LHWORD    (LHWORD),
    .WRBYTE    (WRBYTE),
    .INCFIFO   (INCFIFO),
    .DECFIFO   (DECFIFO),
    .FLUSH     (FLUSH),
    .OD        (OD),
    .BO        (BO),
    .FIFOFULL  (FIFOFULL),
`ifdef DMA_FIFO_ERR_EN
    .OVFERR    (OVFERR),
    .UNFERR    (UNFERR),
`endif
    .FIFOEMPTY (FIFOEMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0; m_bo = 0;
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Apply one cycle of strobes; the model advances at the same clock edge.
  task automatic step(input bit llw, lhw, wrb, inc, dec, fl, input logic [31:0] id);
    bit full, empty;
    LLWORD = llw; LHWORD = lhw; WRBYTE = wrb;
    INCFIFO = inc; DECFIFO = dec; FLUSH = fl; ID = id;
    @(posedge CLK);
    full  = (m_cnt == DEPTH);
    empty = (m_cnt == 0);
    if (fl) begin
      model_reset();
    end else begin
      if (!full) begin
        if (llw) m_mem[m_wr][15:0]  = id[15:0];
        if (lhw) m_mem[m_wr][31:16] = id[31:16];
        if (wrb) m_mem[m_wr][m_bo*8 +: 8] = id[7:0];
      end
      if (inc && full)  m_ovf = 1'b1;
      if (dec && empty) m_unf = 1'b1;
      m_bo = inc ? 0 : (wrb ? (m_bo + 1) % 4 : m_bo);
      if (inc && !full)  begin m_wr = (m_wr + 1) % DEPTH; m_cnt++; end
      if (dec && !empty) begin m_rd = (m_rd + 1) % DEPTH; m_cnt--; end
    end
    #1;
    LLWORD = 0; LHWORD = 0; WRBYTE = 0; INCFIFO = 0; DECFIFO = 0; FLUSH = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", FIFOEMPTY); end
    checks++; if (FIFOFULL !== 1'b0)  begin errors++; $display("FAIL reset_full got=%b exp=0", FIFOFULL); end
    checks++; if (BO !== 2'd0)        begin errors++; $display("FAIL reset_bo got=%0d exp=0", BO); end
`ifdef DMA_FIFO_ERR_EN
    checks++; if ({OVFERR, UNFERR} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {OVFERR, UNFERR}); end
`endif
    @(posedge CLK); #1;
    RST_ = 1'b1;
    model_reset();
  endtask

  task automatic test_word();
    step(1, 1, 0, 1, 0, 0, 32'h12345678);
    checks++; if (FIFOEMPTY !== 1'b0) begin errors++; $display("FAIL word_empty got=%b exp=0", FIFOEMPTY); end
    checks++; if (OD !== 32'h12345678) begin errors++; $display("FAIL word_od got=%h exp=12345678", OD); end
    checks++; if (BO !== 2'd0) begin errors++; $display("FAIL word_bo got=%0d exp=0", BO); end
  endtask

  task automatic test_bytes();
    logic [31:0] bytes;
    bytes = 32'hDDCCBBAA;
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (BO !== 2'(i)) begin errors++; $display("FAIL byte_bo[%0d] got=%0d exp=%0d", i, BO, i); end
      step(0, 0, 1, 0, 0, 0, {24'hFFFFFF, bytes[8*i +: 8]});
    end
    checks++; if (BO !== 2'd0) begin errors++; $display("FAIL byte_bo_wrap got=%0d exp=0", BO); end
    checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL byte_uncommitted got=%b exp=1", FIFOEMPTY); end
    step(0, 0, 0, 1, 0, 0, 0);
    checks++; if (OD !== 32'hDDCCBBAA) begin errors++; $display("FAIL byte_od got=%h exp=ddccbbaa", OD); end
    step(0, 0, 0, 0, 1, 0, 0);
    checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL byte_count1 got_empty=%b exp=1", FIFOEMPTY); end
  endtask

  task automatic test_full();
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 1, 0, 0, 32'(i));
    checks++; if (FIFOFULL !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", FIFOFULL); end
    step(1, 1, 0, 1, 0, 0, 32'hFFFFFFFF);
    checks++; if (FIFOFULL !== 1'b1) begin errors++; $display("FAIL full_ovf_count got=%b exp=1", FIFOFULL); end
    checks++; if (OD !== 32'h0) begin errors++; $display("FAIL full_ovf_od got=%h exp=00000000", OD); end
`ifdef DMA_FIFO_ERR_EN
    checks++; if (OVFERR !== 1'b1) begin errors++; $display("FAIL full_ovferr got=%b exp=1", OVFERR); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (OD !== 32'(i)) begin errors++; $display("FAIL drain_od[%0d] got=%h exp=%h", i, OD, 32'(i)); end
      step(0, 0, 0, 0, 1, 0, 0);
    end
    checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", FIFOEMPTY); end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1, 0, 32'hA0A0A0A0);
    checks++; if (FIFOEMPTY !== 1'b0 || OD !== 32'hA0A0A0A0) begin errors++; $display("FAIL both_at0 got=%b/%h exp=0/a0a0a0a0", FIFOEMPTY, OD); end
    for (int i = 1; i < DEPTH; i++) step(1, 1, 0, 1, 0, 0, 32'hB0 + 32'(i));
    step(1, 1, 0, 1, 1, 0, 32'hEEEEEEEE);
    checks++; if (FIFOFULL !== 1'b0 || OD !== 32'hB1) begin errors++; $display("FAIL both_atfull got=%b/%h exp=0/000000b1", FIFOFULL, OD); end
    step(1, 1, 0, 1, 0, 0, 32'hC0);
    checks++; if (FIFOFULL !== 1'b1) begin errors++; $display("FAIL both_atfull_cnt got=%b exp=1", FIFOFULL); end
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 32'hD0 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 1, 1, 0, 32'hE0 + 32'(i));
      checks++;
      if (OD !== m_mem[m_rd] || FIFOEMPTY !== 1'b0 || FIFOFULL !== 1'b0) begin
        errors++; $display("FAIL both_mid[%0d] got=%h/%b%b exp=%h/00", i, OD, FIFOEMPTY, FIFOFULL, m_mem[m_rd]);
      end
    end
    checks++; if (OD !== 32'hE7) begin errors++; $display("FAIL both_wrap_head got=%h exp=000000e7", OD); end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    checks++; if (FIFOEMPTY !== 1'b0 || OD !== 32'hE9) begin errors++; $display("FAIL both_cnt3a got=%b/%h exp=0/000000e9", FIFOEMPTY, OD); end
    step(0, 0, 0, 0, 1, 0, 0);
    checks++; if (FIFOEMPTY !== 1'b1) begin errors++; $display("FAIL both_cnt3b got=%b exp=1", FIFOEMPTY); end
  endtask

  task automatic test_flush_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0, 0, 32'h11111111);
    step(0, 0, 1, 0, 0, 0, 32'h22);
    step(0, 0, 1, 0, 0, 0, 32'h33);
    step(0, 0, 0, 1, 0, 1, 0);
    checks++; if (FIFOEMPTY !== 1'b1 || BO !== 2'd0) begin errors++; $display("FAIL flush got=%b/%0d exp=1/0", FIFOEMPTY, BO); end
    step(1, 1, 0, 1, 0, 0, 32'h44444444);
    step(0, 0, 1, 0, 0, 0, 32'h55);
    step(0, 0, 1, 0, 0, 0, 32'h66);
    #2 RST_ = 1'b0;
    #1;
    checks++; if (FIFOEMPTY !== 1'b1 || FIFOFULL !== 1'b0 || BO !== 2'd0) begin
      errors++; $display("FAIL async_reset got=%b%b/%0d exp=10/0", FIFOEMPTY, FIFOFULL, BO);
    end
    model_reset();
    @(posedge CLK); #1;
    RST_ = 1'b1;
  endtask

  task automatic test_underflow();
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    checks++; if (FIFOEMPTY !== 1'b1 || FIFOFULL !== 1'b0) begin errors++; $display("FAIL unf_count got=%b%b exp=10", FIFOEMPTY, FIFOFULL); end
`ifdef DMA_FIFO_ERR_EN
    checks++; if (UNFERR !== 1'b1) begin errors++; $display("FAIL unferr got=%b exp=1", UNFERR); end
`endif
    step(1, 1, 0, 1, 0, 0, 32'h5A5A0001);
    checks++; if (OD !== 32'h5A5A0001) begin errors++; $display("FAIL unf_ptr got=%h exp=5a5a0001", OD); end
`ifdef DMA_FIFO_ERR_EN
    checks++; if (UNFERR !== 1'b1) begin errors++; $display("FAIL unferr_sticky got=%b exp=1", UNFERR); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++; if (UNFERR !== 1'b0) begin errors++; $display("FAIL unferr_flush got=%b exp=0", UNFERR); end
`endif
  endtask

  task automatic test_random();
    bit llw, lhw, wrb, inc, dec, fl, bytemode;
    for (int i = 0; i < 400; i++) begin
      fl       = ($urandom_range(0, 40) == 0);
      inc      = ((i / 40) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      dec      = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      bytemode = $urandom_range(0, 1);
      llw      = !bytemode && $urandom_range(0, 1);
      lhw      = !bytemode && $urandom_range(0, 1);
      wrb      = bytemode && $urandom_range(0, 1);
      if (m_cnt == DEPTH && !inc) begin llw = 0; lhw = 0; wrb = 0; end
      step(llw, lhw, wrb, inc, dec, fl, $urandom);
      checks++;
      if ({FIFOFULL, FIFOEMPTY, BO} !== {m_cnt == DEPTH, m_cnt == 0, 2'(m_bo)}) begin
        errors++; $display("FAIL rand_flags[%0d] got=%b%b/%0d exp=%b%b/%0d", i, FIFOFULL, FIFOEMPTY, BO, m_cnt == DEPTH, m_cnt == 0, m_bo);
      end
      if (m_cnt != 0 && !$isunknown(m_mem[m_rd])) begin
        checks++;
        if (OD !== m_mem[m_rd]) begin errors++; $display("FAIL rand_od[%0d] got=%h exp=%h", i, OD, m_mem[m_rd]); end
      end
`ifdef DMA_FIFO_ERR_EN
      checks++;
      if ({OVFERR, UNFERR} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, {OVFERR, UNFERR}, {m_ovf, m_unf}); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    model_reset();
    test_reset();
    test_word();
    test_bytes();
    test_full();
    test_simultaneous();
    test_flush_reset();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
